fpu_ss_mem_responder: RTL and testbench

- Core-side responder for the coprocessor memory request/result interface driven by fpu_ss: accepts x_mem requests (FP loads/stores), checks alignment, issues them on the core's OBI data port, and returns x_mem_resp in the handshake cycle plus an in-order x_mem_result per successful request.
- Sits in the core/cluster next to the LSU, between fpu_ss and the data bus arbiter.
- Carries the requesting core ID through to the result, for multi-core sharing.

---
 rtl/fpu_ss_pkg.sv | 70 +++++++
 rtl/fpu_ss_mem_outstanding_fifo.sv | 57 +++++
 rtl/fpu_ss_mem_responder.sv | 141 ++++++++++++++
 tb/tb_fpu_ss_mem_responder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem memory interface and its core-side responder.
package fpu_ss_pkg;

    localparam int unsigned X_ID_WIDTH  = 4;
    localparam int unsigned X_MEM_WIDTH = 32;

    // Exception codes returned on x_mem_resp for rejected accesses
    localparam logic [5:0] EXC_LD_MISALIGN = 6'd4;
    localparam logic [5:0] EXC_LD_FAULT    = 6'd5;
    localparam logic [5:0] EXC_ST_MISALIGN = 6'd6;
    localparam logic [5:0] EXC_ST_FAULT    = 6'd7;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [31:0]            addr;
        logic [1:0]             mode;
        logic                   we;
        logic [1:0]             size;
        logic [X_MEM_WIDTH-1:0] wdata;
        logic                   last;
        logic                   spec;
    } x_mem_req_t;

    typedef struct packed {
        logic       exc;
        logic [5:0] exccode;
        logic       dbg;
    } x_mem_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_MEM_WIDTH-1:0] rdata;
        logic                   err;
        logic                   dbg;
    } x_mem_result_t;

    // What must be remembered about a granted access until its bus response returns
    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  we;
        logic [1:0]            size;
        logic [1:0]            offset;
        logic [31:0]           core_id;
    } outstanding_entry_t;

    // Natural alignment check; size 3 (doubleword) is never supported on a 32-bit bus
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] offset);
        logic ok;
        case (size)
            2'd0:    ok = 1'b1;
            2'd1:    ok = ~offset[0];
            2'd2:    ok = (offset == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte enables for an access of the given size starting at lane 0
    function automatic logic [3:0] size_be(input logic [1:0] size);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001;
            2'd1:    be = 4'b0011;
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/fpu_ss_mem_outstanding_fifo.sv
// In-order FIFO of outstanding bus accesses. Push is refused while full even
// if a pop happens in the same cycle (no bypass); pop is ignored while empty.
module fpu_ss_mem_outstanding_fifo
    import fpu_ss_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  outstanding_entry_t wr_data,
    output outstanding_entry_t rd_data,
    output logic               full,
    output logic               empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    outstanding_entry_t mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               do_push;
    logic               do_pop;

    // Explicit wrap so a non power-of-two depth would still behave
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents are only meaningful between push and pop
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fpu_ss_mem_responder.sv
// Core-side responder for fpu_ss memory requests: alignment check, OBI issue,
// same-cycle x_mem_resp and one in-order registered x_mem_result per bus response.
module fpu_ss_mem_responder
    import fpu_ss_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned XLEN            = 32,
    parameter int unsigned NB_CORES        = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             x_mem_valid_i,
    output logic             x_mem_ready_o,
    input  x_mem_req_t       x_mem_req_i,
    output x_mem_resp_t      x_mem_resp_o,
    input  logic [31:0]      mem_dest_core_id_i,
    output logic             x_mem_result_valid_o,
    output x_mem_result_t    x_mem_result_o,
    output logic [31:0]      mem_result_core_id_o,
    output logic             data_req_o,
    input  logic             data_gnt_i,
    output logic [XLEN-1:0]  data_addr_o,
    output logic             data_we_o,
    output logic [3:0]       data_be_o,
    output logic [XLEN-1:0]  data_wdata_o,
    input  logic             data_rvalid_i,
    input  logic [XLEN-1:0]  data_rdata_i,
    input  logic             data_err_i
);

    logic               aligned;
    logic               req_ok;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [1:0]         offset;
    outstanding_entry_t push_entry;
    outstanding_entry_t head;
    logic [XLEN-1:0]    shifted;
    logic [XLEN-1:0]    load_data;

    // Speculation and sequencing hints carry no meaning for this responder
    logic unused_req;
    assign unused_req = ^{x_mem_req_i.mode, x_mem_req_i.last, x_mem_req_i.spec};

    // Request side: alignment, bus drive and handshake response, all same-cycle
    always_comb begin
        offset        = x_mem_req_i.addr[1:0];
        aligned       = is_aligned(x_mem_req_i.size, offset);
        req_ok        = x_mem_valid_i & aligned;
        data_req_o    = req_ok & ~fifo_full;
        push          = data_req_o & data_gnt_i;
        x_mem_ready_o = (x_mem_valid_i & ~aligned) | push;

        x_mem_resp_o = '0;
        if (x_mem_valid_i && !aligned) begin
            x_mem_resp_o.exc = 1'b1;
            if (x_mem_req_i.size == 2'd3)
                x_mem_resp_o.exccode = x_mem_req_i.we ? EXC_ST_FAULT : EXC_LD_FAULT;
            else
                x_mem_resp_o.exccode = x_mem_req_i.we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
        end

        data_addr_o  = '0;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_wdata_o = '0;
        if (req_ok) begin
            data_addr_o  = {x_mem_req_i.addr[XLEN-1:2], 2'b00};
            data_we_o    = x_mem_req_i.we;
            data_be_o    = size_be(x_mem_req_i.size) << offset;
            data_wdata_o = x_mem_req_i.wdata << {offset, 3'b000};
        end

        push_entry.id      = x_mem_req_i.id;
        push_entry.we      = x_mem_req_i.we;
        push_entry.size    = x_mem_req_i.size;
        push_entry.offset  = offset;
        push_entry.core_id = mem_dest_core_id_i;
    end

    // A response with nothing outstanding (e.g. after a reset) is dropped
    assign pop = data_rvalid_i & ~fifo_empty;

    fpu_ss_mem_outstanding_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) i_outstanding (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .push    (push),
        .pop     (pop),
        .wr_data (push_entry),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Realign load data to lane 0 and zero-extend to the access size
    always_comb begin
        shifted = data_rdata_i >> {head.offset, 3'b000};
        case (head.size)
            2'd0:    load_data = XLEN'(shifted[7:0]);
            2'd1:    load_data = XLEN'(shifted[15:0]);
            default: load_data = shifted;
        endcase
        if (head.we) load_data = '0;
    end

    // One-cycle result pulse for every popped bus response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_mem_result_valid_o <= 1'b0;
            x_mem_result_o       <= '0;
            mem_result_core_id_o <= '0;
        end else begin
            x_mem_result_valid_o <= pop;
            if (pop) begin
                x_mem_result_o.id    <= head.id;
                x_mem_result_o.rdata <= load_data;
                x_mem_result_o.err   <= data_err_i;
                x_mem_result_o.dbg   <= 1'b0;
                mem_result_core_id_o <= head.core_id;
            end
        end
    end

`ifndef SYNTHESIS
    // Protocol sanity: stray bus responses and out-of-range core IDs
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(data_rvalid_i && fifo_empty))
                else $warning("data_rvalid_i with no outstanding access, response dropped");
            if (push)
                assert (mem_dest_core_id_i < 32'(NB_CORES))
                    else $error("core id %0d out of range", mem_dest_core_id_i);
        end
    end
`endif

endmodule

// File: tb/tb_fpu_ss_mem_responder.sv
// Scoreboard bench: driver issues requests and bus responses, a monitor checks result pulses.
module tb_fpu_ss_mem_responder;
    import fpu_ss_pkg::*;

    localparam int MAXO = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          x_mem_valid;
    logic          x_mem_ready;
    x_mem_req_t    x_mem_req;
    x_mem_resp_t   x_mem_resp;
    logic [31:0]   dest_core;
    logic          res_valid;
    x_mem_result_t res;
    logic [31:0]   res_core;
    logic          data_req;
    logic          data_gnt;
    logic [31:0]   data_addr;
    logic          data_we;
    logic [3:0]    data_be;
    logic [31:0]   data_wdata;
    logic          data_rvalid;
    logic [31:0]   data_rdata;
    logic          data_err;

    always #5 clk = ~clk;

    fpu_ss_mem_responder #(.MAX_OUTSTANDING(MAXO), .XLEN(32), .NB_CORES(8)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .x_mem_valid_i(x_mem_valid), .x_mem_ready_o(x_mem_ready),
        .x_mem_req_i(x_mem_req), .x_mem_resp_o(x_mem_resp),
        .mem_dest_core_id_i(dest_core),
        .x_mem_result_valid_o(res_valid), .x_mem_result_o(res),
        .mem_result_core_id_o(res_core),
        .data_req_o(data_req), .data_gnt_i(data_gnt), .data_addr_o(data_addr),
        .data_we_o(data_we), .data_be_o(data_be), .data_wdata_o(data_wdata),
        .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata), .data_err_i(data_err)
    );

    typedef struct {
        logic [3:0]  id;
        logic        we;
        logic [1:0]  size;
        logic [1:0]  off;
        logic [31:0] core;
    } out_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] core;
        int          due;
    } exp_t;

    out_t bus_q[$];
    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: byte-lane view of a naturally aligned access
    function automatic logic m_aligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b0;
        return (a % (32'd1 << sz)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        be = '0;
        for (int b = 0; b < (1 << sz); b++) be[int'(off) + b] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] off);
        logic [31:0] w;
        w = '0;
        for (int b = 0; int'(off) + b < 4; b++) w[8*(int'(off)+b) +: 8] = wd[8*b +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < (1 << sz); b++) r[8*b +: 8] = rd[8*(int'(off)+b) +: 8];
        return r;
    endfunction

    // Monitor: every result pulse must match the oldest expectation, on its cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                checks++; errors++;
                $display("FAIL result_missing: got no pulse want id=%0d at cycle %0d", exp_q[0].id, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got pulse id=%0d want none", res.id);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("res_cycle", 64'(cyc), 64'(mon_e.due));
                    chk("res_id", 64'(res.id), 64'(mon_e.id));
                    chk("res_rdata", 64'(res.rdata), 64'(mon_e.rdata));
                    chk("res_err", 64'(res.err), 64'(mon_e.err));
                    chk("res_dbg", 64'(res.dbg), 64'd0);
                    chk("res_core", 64'(res_core), 64'(mon_e.core));
                end
            end
        end
    end

    task automatic set_idle();
        x_mem_valid = 1'b0;
        x_mem_req   = '0;
        dest_core   = '0;
    endtask

    task automatic drive_req(input logic [3:0] id, input logic [31:0] addr, input logic we,
                             input logic [1:0] sz, input logic [31:0] wd, input logic [31:0] core);
        x_mem_valid       = 1'b1;
        x_mem_req         = '0;
        x_mem_req.id      = id;
        x_mem_req.addr    = addr;
        x_mem_req.we      = we;
        x_mem_req.size    = sz;
        x_mem_req.wdata   = wd;
        x_mem_req.mode    = 2'($urandom);
        x_mem_req.last    = 1'($urandom);
        x_mem_req.spec    = 1'($urandom);
        dest_core         = core;
    endtask

    // Hold the driven request until accepted; checks the bus side every cycle
    task automatic wait_accept(input bit rand_gnt, output int stalls);
        logic [1:0]  off;
        logic [5:0]  ec;
        bit          done;
        out_t        o;
        off = x_mem_req.addr[1:0];
        stalls = 0;
        done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            data_gnt = rand_gnt ? 1'($urandom) : 1'b1;
            @(negedge clk);
            if (!m_aligned(x_mem_req.size, x_mem_req.addr)) begin
                ec = (x_mem_req.size == 2'd3) ? (x_mem_req.we ? 6'd7 : 6'd5) : (x_mem_req.we ? 6'd6 : 6'd4);
                chk("mis_ready", 64'(x_mem_ready), 64'd1);
                chk("mis_data_req", 64'(data_req), 64'd0);
                chk("mis_exc", 64'(x_mem_resp.exc), 64'd1);
                chk("mis_exccode", 64'(x_mem_resp.exccode), 64'(ec));
                done = 1;
            end else begin
                chk("data_req", 64'(data_req), 64'(bus_q.size() < MAXO));
                if (data_req && data_gnt) begin
                    chk("ready", 64'(x_mem_ready), 64'd1);
                    chk("exc", 64'(x_mem_resp.exc), 64'd0);
                    chk("resp_dbg", 64'(x_mem_resp.dbg), 64'd0);
                    chk("addr", 64'(data_addr), 64'(x_mem_req.addr & 32'hFFFF_FFFC));
                    chk("we", 64'(data_we), 64'(x_mem_req.we));
                    chk("be", 64'(data_be), 64'(m_be(x_mem_req.size, off)));
                    chk("wdata", 64'(data_wdata), 64'(m_wdata(x_mem_req.wdata, off)));
                    o.id = x_mem_req.id; o.we = x_mem_req.we; o.size = x_mem_req.size;
                    o.off = off; o.core = dest_core;
                    bus_q.push_back(o);
                    done = 1;
                end else begin
                    chk("stall_ready", 64'(x_mem_ready), 64'd0);
                    stalls++;
                end
            end
            @(posedge clk); #1;
        end
        set_idle();
        data_gnt = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no handshake want handshake for id=%0d", x_mem_req.id);
        end
    endtask

    // Raise rvalid for the current cycle and record what the model expects back
    task automatic bus_return(input logic [31:0] rd, input logic err);
        out_t o;
        exp_t e;
        data_rvalid = 1'b1;
        data_rdata  = rd;
        data_err    = err;
        if (bus_q.size() > 0) begin
            o = bus_q.pop_front();
            e.id    = o.id;
            e.rdata = o.we ? 32'd0 : m_load(rd, o.size, o.off);
            e.err   = err;
            e.core  = o.core;
            e.due   = cyc + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic bus_pulse(input logic [31:0] rd, input logic err);
        bus_return(rd, err);
        @(posedge clk); #1;
        data_rvalid = 1'b0;
        data_err    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        logic [1:0]  sz;
        logic [31:0] a;
        set_idle();
        data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0; data_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive_req(4'd1, 32'h1004, 1'b0, 2'd2, 32'h0, 32'd0);
        set_idle();
        @(negedge clk);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_res_core", 64'(res_core), 64'd0);
        chk("idle_ready", 64'(x_mem_ready), 64'd0);
        chk("idle_data_req", 64'(data_req), 64'd0);
        chk("idle_resp", 64'(x_mem_resp), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Word load, response two cycles after the grant
        drive_req(4'd3, 32'h1004, 1'b0, 2'd2, 32'h0, 32'd0);
        wait_accept(0, st);
        idle(1);
        bus_pulse(32'hDEADBEEF, 1'b0);

        // Byte store to the top lane
        drive_req(4'd4, 32'h2003, 1'b1, 2'd0, 32'h0000_00AB, 32'd1);
        wait_accept(0, st);
        bus_pulse(32'h1234_5678, 1'b0);

        // Rejected accesses: misaligned half and unsupported doubleword
        drive_req(4'd6, 32'h3001, 1'b0, 2'd1, 32'h0, 32'd0); wait_accept(0, st);
        drive_req(4'd6, 32'h3001, 1'b1, 2'd1, 32'h0, 32'd0); wait_accept(0, st);
        drive_req(4'd7, 32'h3000, 1'b0, 2'd3, 32'h0, 32'd0); wait_accept(0, st);
        drive_req(4'd7, 32'h3000, 1'b1, 2'd3, 32'h0, 32'd0); wait_accept(0, st);
        drive_req(4'd7, 32'h3002, 1'b0, 2'd2, 32'h0, 32'd0); wait_accept(0, st);
        idle(3);

        // Fill the FIFO, third request stalls until a pop, then enters next cycle
        drive_req(4'd0, 32'h4000, 1'b0, 2'd2, 32'h0, 32'd2); wait_accept(0, st);
        drive_req(4'd1, 32'h4006, 1'b0, 2'd1, 32'h0, 32'd3); wait_accept(0, st);
        drive_req(4'd2, 32'h4009, 1'b0, 2'd0, 32'h0, 32'd4);
        data_gnt = 1'b1;
        @(negedge clk);
        chk("full_data_req", 64'(data_req), 64'd0);
        chk("full_ready", 64'(x_mem_ready), 64'd0);
        @(posedge clk); #1;
        bus_return(32'hA1B2_C3D4, 1'b0);
        @(negedge clk);
        chk("full_pop_data_req", 64'(data_req), 64'd0);
        @(posedge clk); #1;
        data_rvalid = 1'b0;
        wait_accept(0, st);
        chk("after_pop_stalls", 64'(st), 64'd0);
        // Back-to-back responses
        bus_return(32'h5566_7788, 1'b0);
        @(posedge clk); #1;
        bus_return(32'h99AA_BBCC, 1'b0);
        @(posedge clk); #1;
        data_rvalid = 1'b0;

        // Bus error and core ID pass-through
        drive_req(4'd5, 32'h5000, 1'b0, 2'd2, 32'h0, 32'd5); wait_accept(0, st);
        bus_pulse(32'hCAFE_F00D, 1'b1);
        idle(2);

        // Stray response with nothing outstanding
        bus_pulse(32'h1111_2222, 1'b0);
        idle(3);

        // Reset with two outstanding; late responses must vanish
        drive_req(4'd8, 32'h6000, 1'b0, 2'd2, 32'h0, 32'd1); wait_accept(0, st);
        drive_req(4'd9, 32'h6004, 1'b1, 2'd2, 32'h0, 32'd1); wait_accept(0, st);
        rst_n = 1'b0;
        bus_q.delete();
        @(negedge clk);
        chk("midrst_res_valid", 64'(res_valid), 64'd0);
        chk("midrst_res_core", 64'(res_core), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        bus_pulse(32'h3333_4444, 1'b0);
        bus_pulse(32'h5555_6666, 1'b0);
        idle(3);
        drive_req(4'd10, 32'h7000, 1'b0, 2'd2, 32'h0, 32'd0);
        wait_accept(0, st);
        chk("post_rst_accept_stalls", 64'(st), 64'd0);
        bus_pulse(32'h7777_8888, 1'b0);

        // Random traffic with random grants and response timing
        for (int i = 0; i < 120; i++) begin
            if (bus_q.size() == MAXO || (bus_q.size() > 0 && $urandom_range(0, 1) == 1))
                bus_pulse($urandom, ($urandom_range(0, 7) == 0));
            sz = 2'($urandom_range(0, 3));
            a  = 32'h8000_0000 | ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
            drive_req(4'(i), a, 1'($urandom), sz, $urandom, 32'($urandom_range(0, 7)));
            wait_accept(1, st);
        end
        while (bus_q.size() > 0) bus_pulse($urandom, 1'($urandom));
        idle(4);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
